nerv_fetch_queue: RTL and testbench
===================================

Name: nerv_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the nerv pipeline. It decouples the 1-cycle-latency instruction memory from decode using a DEPTH-entry queue of {pc, insn} pairs.
- Decode consumes entries with a valid/ready handshake. A redirect from execute (taken branch, jump, trap vector) flushes the queue and any in-flight fetch.
- Successor to the single-register fetch path. Adds buffering, backpressure, in-flight squash and optional static branch prediction.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_valid  out  1  fetch request this cycle.
- imem_addr  out  32  fetch address, word-aligned; imem_data returns it one cycle later.
- imem_data  in  32  instruction for the request of the previous cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored (treated as 0).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  pc of the head entry.
- out_insn  out  32  instruction of the head entry.
- out_pred_taken  out  1  head was predicted taken (optional feature only).
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - fetch_pc: next sequential fetch address.
  - req_q: a request was issued last cycle.
  - req_pc_q: the pc of that request.
  - squash_q: drop the response arriving this cycle.
  - Queue storage with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus count.
- Reset (async) values:
  - fetch_pc=RESET_ADDR; req_q=0; squash_q=0; pointers=0; count=0.
  - Outputs: out_valid=0, imem_valid=0, count=0, out_pred_taken=0.
  - out_pc and out_insn are don't-care while out_valid=0.
- Issue rule:
  - imem_valid=1 when count + req_q < DEPTH, or when redirect_valid=1.
  - Credit is conservative: a same-cycle pop is not counted.
  - imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc.
  - On issue: fetch_pc <= imem_addr+4, req_q <= 1, req_pc_q <= imem_addr. Otherwise req_q <= 0.
- Response push:
  - When req_q=1, squash_q=0 and redirect_valid=0, write {req_pc_q, imem_data} at wr_ptr and increment wr_ptr.
  - The credit rule guarantees a push never occurs when the queue is full.
- Pop: out_valid = (count != 0). When out_valid & out_ready, increment rd_ptr.
- Count:
  - push only: +1. pop only: -1. push and pop together: unchanged.
  - Push and pop together is legal at full and at count=1.
- Redirect (highest priority):
  - Same cycle: count <= 0, rd_ptr <= wr_ptr, and the in-flight response is discarded.
  - The new request goes out that same cycle.
  - A pop in the redirect cycle still completes: the head is consumed, then the flush applies.
  - The first entry after a redirect appears two cycles later (out_valid=1 at redirect cycle +2).
- Reset asserted mid-operation clears all state immediately. Fetch restarts at RESET_ADDR on the first clock edge after reset deasserts.
- Throughput: with out_ready held 1 and no redirect, one instruction per cycle in steady state.

Optional Feature:
- Macro: NERV_FETCH_BTFN_EN.
- Defined:
  - Each pushed instruction is predecoded.
  - Predicted taken when opcode=7'b1100011 (branch) with imm sign bit insn[31]=1, or opcode=7'b1101111 (JAL).
  - For a predicted-taken push: store pred_taken=1, set fetch_pc <= req_pc_q + sign-extended B/J immediate, and set squash_q <= 1 so the next response is dropped.
  - This costs one bubble. Queue entries gain a 1-bit pred_taken field.
  - A redirect in the same cycle overrides the prediction and clears squash_q.
- Undefined: out_pred_taken is tied to 0, no predecode logic exists, and fetch is strictly sequential.

Test Plan:
- Fill to full, DEPTH=4, RESET_ADDR=0, out_ready=0: entries pc 0x0,0x4,0x8,0xC are queued, count=4, imem_valid=0, and no further requests are issued.
- Streaming with out_ready=1: after the 2-cycle fill, out_pc increments by 4 every cycle with no gaps; one push and one pop per cycle at count=1 leaves count constant.
- Redirect to 0x100 while the queue holds 3 entries and a fetch is in flight: count=0 next cycle, the in-flight word is never delivered, and the next out_pc=0x100 appears two cycles after the redirect.
- Async reset at count=2 mid-stream: out_valid=0 and count=0 immediately; after release, the first out_pc=RESET_ADDR.
- Pop and redirect in the same cycle: the head is consumed exactly once and no stale entry follows.
- With NERV_FETCH_BTFN_EN, BEQ at 0x10 with imm -8: entry 0x10 has pred_taken=1, the next out_pc=0x08, and 0x14 never appears. Without the macro: pred_taken=0 and the next out_pc=0x14.

Source files
------------

// File: rtl/nerv_fetch_queue.sv
// nerv_fetch_queue: instruction-fetch front end for the nerv pipeline.
// Buffers {pc, insn} pairs from a 1-cycle-latency instruction memory in a
// DEPTH-entry queue and hands them to decode over a valid/ready port.
// A redirect from execute flushes the queue and squashes the in-flight fetch.
// Optional static BTFN prediction is enabled by defining NERV_FETCH_BTFN_EN.
//
// Output handshake: an entry transfers on a rising clock edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
// out_pc/out_insn/out_pred_taken stay stable while out_valid=1 and no
// transfer or redirect takes place.

module nerv_fetch_queue #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          DEPTH      = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       imem_valid,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_insn,
   output logic                       out_pred_taken,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   fetch_pc;
   logic          req_q;
   logic [31:0]   req_pc_q;
   logic          squash_q;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   insn_mem [DEPTH];

   logic [CW:0]   credit;
   logic          issue;
   logic          push;
   logic          pop;

   // The low address bits of a redirect are discarded by the alignment.
   logic          unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Issue credit counts entries held plus the response still in flight;
   // a same-cycle pop is deliberately not credited.
   always_comb begin
      credit     = {1'b0, count_q} + {{CW{1'b0}}, req_q};
      issue      = !reset && (redirect_valid || (credit < (CW+1)'(DEPTH)));
      imem_valid = issue;
      imem_addr  = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc;
      push       = req_q && !squash_q && !redirect_valid;
      pop        = out_valid && out_ready;
   end

`ifdef NERV_FETCH_BTFN_EN
   logic          pred_mem [DEPTH];
   logic [6:0]    opcode;
   logic          is_jal;
   logic          pred_taken;
   logic          pred_push;
   logic [31:0]   b_imm;
   logic [31:0]   j_imm;
   logic [31:0]   pred_target;

   // Predecode the returning word: backward branches and JAL are taken.
   always_comb begin
      opcode      = imem_data[6:0];
      is_jal      = (opcode == 7'b1101111);
      pred_taken  = is_jal || ((opcode == 7'b1100011) && imem_data[31]);
      pred_push   = push && pred_taken;
      b_imm       = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25],
                     imem_data[11:8], 1'b0};
      j_imm       = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20],
                     imem_data[30:21], 1'b0};
      pred_target = req_pc_q + (is_jal ? j_imm : b_imm);
   end
`endif

   // Fetch address sequencing and in-flight request tracking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_ADDR;
         req_q    <= 1'b0;
         req_pc_q <= RESET_ADDR;
         squash_q <= 1'b0;
      end else begin
         squash_q <= 1'b0;
         if (issue) begin
            fetch_pc <= imem_addr + 32'd4;
            req_q    <= 1'b1;
            req_pc_q <= imem_addr;
         end else begin
            req_q    <= 1'b0;
         end
`ifdef NERV_FETCH_BTFN_EN
         // A predicted-taken push steers fetch to the target and drops the
         // sequential word issued this cycle. Never coincides with a redirect.
         if (pred_push) begin
            fetch_pc <= pred_target;
            squash_q <= 1'b1;
         end
`endif
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (redirect_valid) begin
         rd_ptr  <= wr_ptr;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (!push && pop) count_q <= count_q - CW'(1);
      end
   end

   // Entry storage; contents are meaningful only between rd_ptr and wr_ptr.
   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc_q;
         insn_mem[wr_ptr] <= imem_data;
`ifdef NERV_FETCH_BTFN_EN
         pred_mem[wr_ptr] <= pred_taken;
`endif
      end
   end

   // Head-of-queue presentation.
   always_comb begin
      out_valid = (count_q != '0);
      out_pc    = pc_mem[rd_ptr];
      out_insn  = insn_mem[rd_ptr];
      count     = count_q;
`ifdef NERV_FETCH_BTFN_EN
      out_pred_taken = out_valid && pred_mem[rd_ptr];
`else
      out_pred_taken = 1'b0;
`endif
   end

endmodule

// File: tb/tb_nerv_fetch_queue.sv
// Testbench for nerv_fetch_queue (DEPTH=4, RESET_ADDR=0). Expectations follow
// the NERV_FETCH_BTFN_EN setting of the build.

module tb_nerv_fetch_queue;

  logic        clock;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        out_pred_taken;
  logic [2:0]  count;

`ifdef NERV_FETCH_BTFN_EN
  localparam bit btfn = 1'b1;
`else
  localparam bit btfn = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic beq_en = 1'b0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;

  nerv_fetch_queue #(.RESET_ADDR(32'h0), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .imem_valid(imem_valid),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_insn(out_insn),
    .out_pred_taken(out_pred_taken),
    .count(count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory image: address-tagged ALU words, plus "beq x0,x0,-8" at 0x10
  function automatic logic [31:0] word(input logic [31:0] addr);
    if (beq_en && addr == 32'h10) return 32'hFE000CE3;
    return {addr[24:0], 7'h13};
  endfunction

  // 1-cycle-latency instruction memory
  always @(posedge clock) begin
    if (imem_valid) imem_data <= word(imem_addr);
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic pred);
    exp_q.push_back({pred, pc, word(pc)});
  endtask

  // scoreboard monitor: every completed transfer is compared with the queue
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_pred_taken, out_pc, out_insn} !== mon_e) begin
          failures++;
          $display("FAIL pop actual=%b/%h/%h expected=%b/%h/%h",
                   out_pred_taken, out_pc, out_insn, mon_e[64], mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    imem_data = 32'h0;
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("rst_pred", {31'b0, out_pred_taken}, 32'd0);

    // fill to full with out_ready=0
    reset = 1'b0;                                   // c0
    #1;
    chk("c0_imem_valid", {31'b0, imem_valid}, 32'd1);
    chk("c0_imem_addr", imem_addr, 32'h0);
    tick();                                         // c1
    #1;
    chk("c1_imem_addr", imem_addr, 32'h4);
    repeat (4) tick();                              // c5
    #1;
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_out_pc", out_pc, 32'h0);
    chk("full_out_insn", out_insn, 32'h13);
    tick();                                         // c6
    #1;
    chk("full_count_hold", {29'b0, count}, 32'd4);
    chk("full_no_issue", {31'b0, imem_valid}, 32'd0);

    // stream from full: no gaps
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i), 1'b0);
    tick();                                         // c7
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      out_ready = 1'b1;
      #1;
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_pc", out_pc, 32'(4 * i));
    end

    // build 3 entries + 1 in flight, then redirect
    tick();                                         // c15
    out_ready = 1'b0;
    #1;
    chk("pre_redir_count2", {29'b0, count}, 32'd2);
    tick();                                         // c16
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("redir_count3", {29'b0, count}, 32'd3);
    chk("redir_imem_valid", {31'b0, imem_valid}, 32'd1);
    chk("redir_imem_addr", imem_addr, 32'h100);
    tick();                                         // c17
    redirect_valid = 1'b0;
    #1;
    chk("post_redir_count", {29'b0, count}, 32'd0);
    chk("post_redir_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 5; i++) push_exp(32'h100 + 32'(4 * i), 1'b0);
    tick();                                         // c18
    out_ready = 1'b1;
    #1;
    chk("redir_plus2_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_plus2_pc", out_pc, 32'h100);
    chk("steady_count", {29'b0, count}, 32'd1);
    for (int i = 0; i < 3; i++) begin               // c19..c21
      tick();
      #1;
      chk("steady_count", {29'b0, count}, 32'd1);
    end

    // pop and redirect in the same cycle
    tick();                                         // c22
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("popredir_head", out_pc, 32'h110);
    tick();                                         // c23
    redirect_valid = 1'b0;
    #1;
    chk("popredir_valid", {31'b0, out_valid}, 32'd0);
    chk("popredir_count", {29'b0, count}, 32'd0);
    push_exp(32'h200, 1'b0);
    push_exp(32'h204, 1'b0);
    tick();                                         // c24
    #1;
    chk("popredir_next_pc", out_pc, 32'h200);
    tick();                                         // c25
    tick();                                         // c26
    out_ready = 1'b0;
    #1;
    chk("pre_reset_count1", {29'b0, count}, 32'd1);

    // async reset at count=2
    tick();                                         // c27
    #1;
    chk("pre_reset_count2", {29'b0, count}, 32'd2);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_count", {29'b0, count}, 32'd0);
    chk("midrst_imem_valid", {31'b0, imem_valid}, 32'd0);
    beq_en = 1'b1;
    tick();
    reset = 1'b0;                                   // d0
    out_ready = 1'b1;
    #1;
    chk("restart_imem_addr", imem_addr, 32'h0);
    chk("restart_imem_valid", {31'b0, imem_valid}, 32'd1);
    for (int i = 0; i < 4; i++) push_exp(32'(4 * i), 1'b0);
    push_exp(32'h10, btfn);
    if (btfn) begin
      push_exp(32'h08, 1'b0);
      push_exp(32'h0C, 1'b0);
    end else begin
      push_exp(32'h14, 1'b0);
      push_exp(32'h18, 1'b0);
      push_exp(32'h1C, 1'b0);
    end
    tick();                                         // d1
    tick();                                         // d2
    #1;
    chk("restart_first_pc", out_pc, 32'h0);
    repeat (4) tick();                              // d6
    #1;
    chk("beq_pc", out_pc, 32'h10);
    chk("beq_pred", {31'b0, out_pred_taken}, {31'b0, btfn});
    tick();                                         // d7
    #1;
    chk("after_beq_valid", {31'b0, out_valid}, btfn ? 32'd0 : 32'd1);
    tick();                                         // d8
    #1;
    chk("after_beq_pc", out_pc, btfn ? 32'h08 : 32'h18);
    tick();                                         // d9
    tick();                                         // d10
    out_ready = 1'b0;
    repeat (3) tick();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
